// File: rtl/hub75_bcm_scheduler.sv
// hub75_bcm_scheduler: HUB75 row / bit-plane BCM refresh sequencer. It owns row_addr, lat and oe,
// and asks the pixel shifter for one row-plane of column data at a time.
// Ports: clk / reset (sync, active-high); enable starts and stops refresh; brightness scales the OE window;
//        shift_req/shift_row/shift_plane/shift_done form the handshake with the pixel shifter;
//        row_addr/lat/oe drive the panel; frame_start, busy and frame_cnt report status.
// Optional feature: define HUB75_BCM_FRAME_CNT_EN to build the completed-frame counter. Without it,
//        frame_cnt is tied to 0.
// Latency: shift_req rises 1 cycle after enable. Each row-plane then takes the handshake cycles,
//        1 cycle for req drop, DEAD_TICKS, 1 LATCH cycle and the window.
// Backpressure: the block waits in SHIFT for as long as shift_done stays low.

module hub75_bcm_scheduler #(
   parameter int ROWS_PER_GROUP = 16,
   parameter int BITPLANES      = 4,
   parameter int BASE_TICKS     = 64,
   parameter int DEAD_TICKS     = 2,
   parameter bit OE_ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  brightness,
   input  logic        shift_done,
   output logic        shift_req,
   output logic [3:0]  shift_row,
   output logic [2:0]  shift_plane,
   output logic [3:0]  row_addr,
   output logic        lat,
   output logic        oe,
   output logic        frame_start,
   output logic        busy,
   output logic [15:0] frame_cnt
);

   // The largest window, BASE_TICKS << (BITPLANES-1), fits in TW bits.
   // The brightness product needs 8 more bits, and nothing is truncated before the >> 8.
   localparam int TW = $clog2(BASE_TICKS) + BITPLANES;
   localparam int PW = TW + 8;
   localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

   localparam logic OE_ON  = OE_ACTIVE_LOW ? 1'b0 : 1'b1;
   localparam logic OE_OFF = OE_ACTIVE_LOW ? 1'b1 : 1'b0;

   localparam logic [3:0]    LAST_ROW   = 4'(ROWS_PER_GROUP - 1);
   localparam logic [2:0]    LAST_PLANE = 3'(BITPLANES - 1);
   localparam logic [DW-1:0] LAST_DEAD  = DW'(DEAD_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      BLANK,
      LATCH,
      SHOW
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    row, row_nxt;
   logic [2:0]    plane, plane_nxt;
   logic [TW-1:0] t, t_nxt;
   logic [DW-1:0] dead_cnt, dead_nxt;
   logic [7:0]    bri_reg, bri_nxt;

   logic          shift_req_nxt;
   logic [3:0]    shift_row_nxt;
   logic [2:0]    shift_plane_nxt;
   logic [3:0]    row_addr_nxt;
   logic          lat_nxt;
   logic          oe_nxt;
   logic          frame_start_nxt;

   logic [TW-1:0] window;
   logic [PW-1:0] product;
   logic [PW-1:0] on_ticks;
   logic          t_last;
   logic          row_last;
   logic          plane_last;
   logic [3:0]    row_adv;
   logic [2:0]    plane_adv;

   // Window geometry for the plane being shown. bri_reg only changes on entry to LATCH,
   // so a brightness change mid-window does not take effect until the next row-plane.
   assign window     = TW'(BASE_TICKS) << plane;
   assign product    = PW'(window) * (PW'(bri_reg) + PW'(1));
   assign on_ticks   = product >> 8;
   assign t_last     = (t == (window - TW'(1)));
   assign row_last   = (row == LAST_ROW);
   assign plane_last = (plane == LAST_PLANE);
   assign plane_adv  = plane_last ? 3'd0 : plane + 3'd1;
   assign row_adv    = plane_last ? (row_last ? 4'd0 : row + 4'd1) : row;

   // Every output is registered. Its next value is computed here together with the next state,
   // so each output lines up with the state it belongs to.
   always_comb begin
      state_nxt       = state;
      row_nxt         = row;
      plane_nxt       = plane;
      t_nxt           = t;
      dead_nxt        = dead_cnt;
      bri_nxt         = bri_reg;
      shift_req_nxt   = 1'b0;
      shift_row_nxt   = shift_row;
      shift_plane_nxt = shift_plane;
      row_addr_nxt    = row_addr;
      lat_nxt         = 1'b0;
      oe_nxt          = OE_OFF;
      frame_start_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (enable) begin
               state_nxt       = SHIFT;
               row_nxt         = 4'd0;
               plane_nxt       = 3'd0;
               shift_req_nxt   = 1'b1;
               shift_row_nxt   = 4'd0;
               shift_plane_nxt = 3'd0;
               frame_start_nxt = 1'b1;
            end
         end

         SHIFT: begin
            if (shift_done) begin
               state_nxt = BLANK;
               dead_nxt  = '0;
            end else begin
               shift_req_nxt = 1'b1;
            end
         end

         BLANK: begin
            if (dead_cnt == LAST_DEAD) begin
               // The row address and brightness are captured on entry to LATCH.
               // Both are therefore valid during the single lat cycle.
               state_nxt    = LATCH;
               lat_nxt      = 1'b1;
               row_addr_nxt = row;
               bri_nxt      = brightness;
            end else begin
               dead_nxt = dead_cnt + DW'(1);
            end
         end

         LATCH: begin
            state_nxt = SHOW;
            t_nxt     = '0;
            oe_nxt    = (on_ticks != '0) ? OE_ON : OE_OFF;
         end

         SHOW: begin
            if (t_last) begin
               // enable is only looked at here, so a window that has started always completes.
               if (enable) begin
                  state_nxt       = SHIFT;
                  row_nxt         = row_adv;
                  plane_nxt       = plane_adv;
                  shift_req_nxt   = 1'b1;
                  shift_row_nxt   = row_adv;
                  shift_plane_nxt = plane_adv;
                  frame_start_nxt = (row_adv == 4'd0) && (plane_adv == 3'd0);
               end else begin
                  state_nxt = IDLE;
                  row_nxt   = 4'd0;
                  plane_nxt = 3'd0;
               end
            end else begin
               t_nxt  = t + TW'(1);
               oe_nxt = ((PW'(t) + PW'(1)) < on_ticks) ? OE_ON : OE_OFF;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         row         <= 4'd0;
         plane       <= 3'd0;
         t           <= '0;
         dead_cnt    <= '0;
         bri_reg     <= 8'd0;
         shift_req   <= 1'b0;
         shift_row   <= 4'd0;
         shift_plane <= 3'd0;
         row_addr    <= 4'd0;
         lat         <= 1'b0;
         oe          <= OE_OFF;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         row         <= row_nxt;
         plane       <= plane_nxt;
         t           <= t_nxt;
         dead_cnt    <= dead_nxt;
         bri_reg     <= bri_nxt;
         shift_req   <= shift_req_nxt;
         shift_row   <= shift_row_nxt;
         shift_plane <= shift_plane_nxt;
         row_addr    <= row_addr_nxt;
         lat         <= lat_nxt;
         oe          <= oe_nxt;
         frame_start <= frame_start_nxt;
         busy        <= (state_nxt != IDLE);
      end
   end

`ifdef HUB75_BCM_FRAME_CNT_EN
   // A frame is complete when the window of the last row and the last plane ends.
   // This holds whether refresh continues or stops.
   logic frame_done;
   assign frame_done = (state == SHOW) && t_last && plane_last && row_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= 16'd0;
      end else if (frame_done) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`else
   assign frame_cnt = 16'd0;
`endif

endmodule
